// File: rtl/nubus_master_seq.sv
// Registered NuBus master sequencer: request, arbitration, address/data cycles, timeout, NULL-ATTN.
// Optional try-again-later re-arbitration is built when NUBUS_RETRY_EN is defined.
module nubus_master_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1),
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        nub_clkn,
  input  logic        nub_reset,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic        cpu_write,
  input  logic        cpu_locked,
  input  logic [1:0]  cpu_tm,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic [1:0]  cpu_status,
  input  logic        arb_won,
  input  logic        bus_idle,
  input  logic        nub_ackn_i,
  input  logic        nub_tm1n_i,
  input  logic        nub_tm0n_i,
  input  logic [31:0] nub_ad_i,
  output logic        nub_rqstn_o,
  output logic        nub_startn_o,
  output logic        nub_ackn_o,
  output logic        nub_tm1n_o,
  output logic        nub_tm0n_o,
  output logic        nub_rqstoe_o,
  output logic        nub_startoe_o,
  output logic        nub_tmoe_o,
  output logic [31:0] nub_ad_o,
  output logic        nub_adoe_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ADDR,
    S_DATA,
    S_ATTN,
    S_RESOLVE
  } state_e;

  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_RETRY   = 2'b11;

  state_e          state_q, state_d;
  logic            write_q, write_d;
  logic            locked_q, locked_d;
  logic [1:0]      tm_q, tm_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]      bus_status_q, bus_status_d;

  logic            rqstn_q, rqstn_d;
  logic            rqstoe_q, rqstoe_d;
  logic            startn_q, startn_d;
  logic            startoe_q, startoe_d;
  logic            ackn_q, ackn_d;
  logic            tm1n_q, tm1n_d;
  logic            tm0n_q, tm0n_d;
  logic            tmoe_q, tmoe_d;
  logic [31:0]     ad_q, ad_d;
  logic            adoe_q, adoe_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      status_q, status_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;

  logic            can_retry;

`ifdef NUBUS_RETRY_EN
  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [RW-1:0] retry_q, retry_d;

  assign can_retry = (retry_q < RW'(MAX_RETRY));

  always_ff @(posedge nub_clkn or posedge nub_reset) begin
    if (nub_reset) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`else
  assign can_retry = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    locked_d     = locked_q;
    tm_d         = tm_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    to_cnt_d     = to_cnt_q;
    bus_status_d = bus_status_q;
    rdata_d      = rdata_q;
    status_d     = status_q;
    ready_d      = 1'b0;
    done_d       = 1'b0;
`ifdef NUBUS_RETRY_EN
    retry_d      = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cpu_valid) begin
          write_d  = cpu_write;
          locked_d = cpu_locked;
          tm_d     = cpu_tm;
          addr_d   = cpu_addr;
          wdata_d  = cpu_wdata;
          ready_d  = 1'b1;
`ifdef NUBUS_RETRY_EN
          retry_d  = '0;
`endif
          state_d  = S_ARB;
        end
      end
      S_ARB: begin
        if (arb_won && bus_idle) begin
          to_cnt_d = '0;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        // The timeout counter measures cycles since the address cycle.
        to_cnt_d = to_cnt_q + 1'b1;
        state_d  = S_DATA;
      end
      S_DATA: begin
        if (!nub_ackn_i) begin
          bus_status_d = {~nub_tm1n_i, ~nub_tm0n_i};
          if (!write_q) begin
            rdata_d = nub_ad_i;
          end
          state_d = locked_q ? S_ATTN : S_RESOLVE;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          bus_status_d = ST_TIMEOUT;
          state_d      = locked_q ? S_ATTN : S_RESOLVE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_ATTN: begin
        state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        to_cnt_d = '0;
        if ((bus_status_q == ST_RETRY) && can_retry) begin
`ifdef NUBUS_RETRY_EN
          retry_d = retry_q + 1'b1;
`endif
          state_d = S_ARB;
        end else begin
          done_d   = 1'b1;
          status_d = bus_status_q;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pad values are decoded from the state being entered so they are registered with it.
    rqstn_d   = 1'b1;
    rqstoe_d  = 1'b0;
    startn_d  = 1'b1;
    startoe_d = 1'b0;
    ackn_d    = 1'b1;
    tm1n_d    = 1'b1;
    tm0n_d    = 1'b1;
    tmoe_d    = 1'b0;
    adoe_d    = 1'b0;
    ad_d      = ad_q;

    case (state_d)
      S_ARB: begin
        rqstoe_d = 1'b1;
        rqstn_d  = 1'b0;
      end
      S_ADDR: begin
        rqstoe_d  = 1'b1;
        rqstn_d   = 1'b0;
        startoe_d = 1'b1;
        startn_d  = 1'b0;
        tmoe_d    = 1'b1;
        tm1n_d    = ~tm_q[1];
        tm0n_d    = ~tm_q[0];
        adoe_d    = 1'b1;
        ad_d      = addr_q;
      end
      S_DATA: begin
        rqstoe_d = locked_q;
        rqstn_d  = ~locked_q;
        adoe_d   = write_q;
        ad_d     = wdata_q;
      end
      S_ATTN: begin
        rqstoe_d  = 1'b1;
        rqstn_d   = 1'b0;
        startoe_d = 1'b1;
        startn_d  = 1'b0;
        tmoe_d    = 1'b1;
        ackn_d    = 1'b0;
        tm1n_d    = 1'b0;
        tm0n_d    = 1'b0;
        adoe_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge nub_clkn or posedge nub_reset) begin
    if (nub_reset) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      locked_q     <= 1'b0;
      tm_q         <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      to_cnt_q     <= '0;
      bus_status_q <= 2'b00;
      rqstn_q      <= 1'b1;
      rqstoe_q     <= 1'b0;
      startn_q     <= 1'b1;
      startoe_q    <= 1'b0;
      ackn_q       <= 1'b1;
      tm1n_q       <= 1'b1;
      tm0n_q       <= 1'b1;
      tmoe_q       <= 1'b0;
      ad_q         <= '0;
      adoe_q       <= 1'b0;
      rdata_q      <= '0;
      status_q     <= 2'b00;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      locked_q     <= locked_d;
      tm_q         <= tm_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      to_cnt_q     <= to_cnt_d;
      bus_status_q <= bus_status_d;
      rqstn_q      <= rqstn_d;
      rqstoe_q     <= rqstoe_d;
      startn_q     <= startn_d;
      startoe_q    <= startoe_d;
      ackn_q       <= ackn_d;
      tm1n_q       <= tm1n_d;
      tm0n_q       <= tm0n_d;
      tmoe_q       <= tmoe_d;
      ad_q         <= ad_d;
      adoe_q       <= adoe_d;
      rdata_q      <= rdata_d;
      status_q     <= status_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
    end
  end

  assign cpu_ready     = ready_q;
  assign cpu_done      = done_q;
  assign cpu_status    = status_q;
  assign cpu_rdata     = rdata_q;
  assign nub_rqstn_o   = rqstn_q;
  assign nub_rqstoe_o  = rqstoe_q;
  assign nub_startn_o  = startn_q;
  assign nub_startoe_o = startoe_q;
  assign nub_ackn_o    = ackn_q;
  assign nub_tm1n_o    = tm1n_q;
  assign nub_tm0n_o    = tm0n_q;
  assign nub_tmoe_o    = tmoe_q;
  assign nub_ad_o      = ad_q;
  assign nub_adoe_o    = adoe_q;

endmodule
